// File: rtl/pwl2real_mc.sv
// Clocked multi-channel pwl-to-real converter: one shared evaluator per cycle,
// pending-first then round-robin, with dead-band, hold refresh and per-channel modes.
package pwl2real_pkg;
  localparam int DW = 32;
  localparam int FW = 16;
  localparam int TW = 32;

  // value(t) = a + b * (t - t0); a, b in Q(DW-FW).FW, b per clock cycle
  typedef struct packed {
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    logic [TW-1:0]        t0;
  } pwl_t;
endpackage

module pwl2real_mc
  import pwl2real_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DV       = 0,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 16,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  pwl_t                 in [NCH],
  input  logic [2*NCH-1:0]     mode,
  input  logic [NCH-1:0]       pk_clr,
  output logic signed [DW-1:0] out [NCH],
  output logic [NCH-1:0]       upd,
  output logic [CHW-1:0]       cur_ch,
  output logic [CW-1:0]        upd_cnt
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int EW = DW + 2;
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  localparam logic [CHW-1:0] CLAST = CHW'(NCH - 1);

  logic [HW-1:0]        hold [NCH];
  pwl_t                 prv [NCH];
  logic                 prv_vld;
  logic [NCH-1:0]       pend;
  logic [NCH-1:0]       clr;
  logic [CHW-1:0]       rr;
  logic [TW-1:0]        now;

  logic [NCH-1:0]       evt;
  logic [NCH-1:0]       clr_eff;
  logic [NCH-1:0]       sel_oh;
  logic [CHW-1:0]       sel;
  logic                 served;
  pwl_t                 p;
  logic [TW-1:0]        dt;
  logic [DW-1:0]        prod;
  logic signed [DW-1:0] v;
  logic signed [EW-1:0] ve;
  logic signed [EW-1:0] oe;
  logic signed [EW-1:0] dve;
  logic signed [EW-1:0] diff;
  logic signed [EW-1:0] ad;
  logic [1:0]           m;
  logic                 hit;
  logic                 do_upd;

  // prv_vld masks the first compare after reset, when prv is not yet loaded
  always_comb begin
    evt = '0;
    for (int k = 0; k < NCH; k++) begin
      evt[k] = prv_vld && (in[k] != prv[k]);
    end
  end

  always_comb begin
    sel = rr;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pend[k]) sel = CHW'(k);
    end
  end

  assign served  = |pend;
  assign clr_eff = clr | pk_clr;
  assign sel_oh  = en ? (NCH'(1) << sel) : '0;

  assign p    = in[sel];
  assign dt   = now - p.t0;
  assign prod = p.b * DW'(dt);
  assign v    = p.a + $signed(prod);

  assign ve   = EW'(v);
  assign oe   = EW'(out[sel]);
  assign dve  = EW'(DV);
  assign diff = ve - oe;
  assign ad   = diff[EW-1] ? -diff : diff;
  assign m    = mode[{sel, 1'b0} +: 2];

  always_comb begin
    hit = 1'b0;
    unique case (m)
      2'd0: hit = (ad >= dve) && (diff != '0);
      2'd1: hit = ve > oe + dve;
      2'd2: hit = ve < oe - dve;
      2'd3: hit = 1'b0;
    endcase
  end

  assign do_upd = en &&
    (clr_eff[sel] || (m != 2'd3 && (hit || hold[sel] >= HMAX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out     <= '{default: '0};
      hold    <= '{default: '0};
      prv     <= '{default: '0};
      prv_vld <= 1'b0;
      pend    <= '1;
      clr     <= '0;
      rr      <= '0;
      now     <= '0;
      upd     <= '0;
      cur_ch  <= '0;
      upd_cnt <= '0;
    end else begin
      now     <= now + TW'(1);
      prv     <= in;
      prv_vld <= 1'b1;
      pend    <= (pend & ~sel_oh) | evt;
      clr     <= clr_eff & ~sel_oh;
      upd     <= '0;
      if (en) begin
        cur_ch <= sel;
        if (!served) rr <= (rr == CLAST) ? '0 : rr + CHW'(1);
        for (int k = 0; k < NCH; k++) begin
          if (do_upd && sel == CHW'(k)) begin
            hold[k] <= '0;
            out[k]  <= v;
            upd[k]  <= 1'b1;
          end else if (hold[k] != HMAX) begin
            hold[k] <= hold[k] + HW'(1);
          end
        end
        if (do_upd) upd_cnt <= upd_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pwl2real_mc.sv
// Randomized bench for pwl2real_mc against a behavioural model,
// plus hand-computed pins for first pass, priority, peak, freeze, en and reset.
module tb_pwl2real_mc;
  import pwl2real_pkg::*;

  localparam int NCH = 4;
  localparam int DVR = 32768;
  localparam int MAXH = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b1;
  pwl_t              din [NCH];
  logic [2*NCH-1:0]  mode = '0;
  logic [NCH-1:0]    pk_clr = '0;
  logic signed [31:0] out [NCH];
  logic [NCH-1:0]    upd;
  logic [1:0]        cur_ch;
  logic [15:0]       upd_cnt;

  int tot = 0;
  int bad = 0;

  int          m_out [NCH];
  int          m_hold [NCH];
  bit [3:0]    m_pend, m_clr, m_upd;
  int          m_rr, m_cur, m_cnt;
  int unsigned m_now;
  bit          m_vld;
  pwl_t        m_prv [NCH];

  pwl2real_mc #(.NCH(NCH), .DV(DVR), .MAX_HOLD(MAXH), .CW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .in(din), .mode(mode),
    .pk_clr(pk_clr), .out(out), .upd(upd), .cur_ch(cur_ch),
    .upd_cnt(upd_cnt)
  );

  always #5 clk = ~clk;

  function automatic int fx(real r);
    return int'(r * 65536.0);
  endfunction

  task automatic chk(string name, longint act, longint exp);
    tot++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic set_ch(int k, int a, int b, int t0);
    din[k].a  = a;
    din[k].b  = b;
    din[k].t0 = t0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_out[k]  = 0;
      m_hold[k] = 0;
      m_prv[k]  = '0;
    end
    m_pend = 4'hF;
    m_clr  = '0;
    m_upd  = '0;
    m_rr   = 0;
    m_cur  = 0;
    m_cnt  = 0;
    m_now  = 0;
    m_vld  = 0;
  endtask

  // Value of a channel's pwl at time t, plain arithmetic
  function automatic longint pwl_val(pwl_t x, int unsigned t);
    longint dt;
    dt = longint'(32'(t - x.t0));
    return longint'(x.a) + longint'(x.b) * dt;
  endfunction

  task automatic model_step();
    bit [3:0] evt, ce;
    int       ch, md;
    longint   v, o;
    bit       go;
    evt = '0;
    for (int k = 0; k < NCH; k++)
      if (m_vld && din[k] != m_prv[k]) evt[k] = 1'b1;
    ce = m_clr | pk_clr;
    m_upd = '0;
    if (en) begin
      ch = -1;
      for (int k = NCH - 1; k >= 0; k--)
        if (m_pend[k]) ch = k;
      if (ch < 0) begin
        ch = m_rr;
        m_rr = (m_rr + 1) % NCH;
      end
      v  = longint'(int'(pwl_val(din[ch], m_now)));
      o  = m_out[ch];
      md = int'(mode[2*ch +: 2]);
      case (md)
        0: go = (v - o >= DVR || o - v >= DVR) && v != o;
        1: go = v > o + DVR;
        2: go = v < o - DVR;
        default: go = 0;
      endcase
      if (md != 3 && m_hold[ch] >= MAXH) go = 1;
      if (ce[ch]) go = 1;
      for (int k = 0; k < NCH; k++) begin
        if (go && k == ch) m_hold[k] = 0;
        else if (m_hold[k] < MAXH) m_hold[k]++;
      end
      if (go) begin
        m_out[ch] = int'(v);
        m_upd[ch] = 1'b1;
        m_cnt = (m_cnt + 1) % 65536;
      end
      m_cur = ch;
      m_pend[ch] = 1'b0;
      ce[ch] = 1'b0;
    end
    m_pend = m_pend | evt;
    m_clr  = ce;
    for (int k = 0; k < NCH; k++) m_prv[k] = din[k];
    m_vld = 1;
    m_now++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < NCH; k++) chk("out", out[k], m_out[k]);
    chk("upd", upd, m_upd);
    chk("cur_ch", cur_ch, m_cur);
    chk("upd_cnt", upd_cnt, m_cnt);
  endtask

  task automatic rand_inputs(bit allow_off);
    en = allow_off ? ($urandom_range(0, 9) != 0) : 1'b1;
    pk_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
    if ($urandom_range(0, 19) == 0) mode = 8'($urandom);
    for (int k = 0; k < NCH; k++) begin
      if ($urandom_range(0, 7) == 0)
        set_ch(k, int'($urandom_range(0, 13107200)) - 6553600,
               int'($urandom_range(0, 131072)) - 65536,
               int'(m_now) - int'($urandom_range(0, 20)));
    end
  endtask

  initial begin
    int found;
    model_reset();
    for (int k = 0; k < NCH; k++) set_ch(k, fx(real'(k + 1)), 0, 0);
    #3;
    chk("rst_out0", out[0], 0);
    chk("rst_cnt", upd_cnt, 0);
    chk("rst_upd", upd, 0);
    #10 rst = 1'b0;

    // first pass after reset: every channel loaded once
    repeat (4) tick();
    chk("t1_out0", out[0], 65536);
    chk("t1_out1", out[1], 131072);
    chk("t1_out2", out[2], 196608);
    chk("t1_out3", out[3], 262144);
    chk("t1_cnt", upd_cnt, 4);

    // pending priority over round-robin
    set_ch(2, fx(7.0), 0, 0);
    tick(); chk("t3_e5", cur_ch, 0);
    tick(); chk("t3_e6", cur_ch, 2);
    chk("t3_out2", out[2], fx(7.0));
    tick(); chk("t3_e7", cur_ch, 1);
    set_ch(1, fx(5.0), 0, 0);
    set_ch(3, fx(6.0), 0, 0);
    tick(); chk("t3_e8", cur_ch, 2);
    tick(); chk("t3_e9", cur_ch, 1);
    tick(); chk("t3_e10", cur_ch, 3);
    chk("t3_cnt", upd_cnt, 7);

    // dead-band ramp on ch0
    set_ch(0, fx(1.0), fx(0.1), int'(m_now));
    repeat (60) tick();

    // peak hold on ch1
    mode[3:2] = 2'd1;
    set_ch(1, 0, 0, 0);
    pk_clr[1] = 1'b1;
    tick();
    pk_clr[1] = 1'b0;
    foreach (din[i]) begin end
    for (int s = 0; s < 9; s++) begin
      int lvl;
      lvl = (s <= 4) ? s : 8 - s;
      set_ch(1, lvl * 32768, 0, 0);
      repeat (2) tick();
    end
    chk("t4_peak", out[1], fx(2.0));
    pk_clr[1] = 1'b1;
    tick();
    pk_clr[1] = 1'b0;
    repeat (4) tick();
    chk("t4_clr", out[1], 0);

    // freeze on ch3, then en low with an event captured
    mode[7:6] = 2'd3;
    set_ch(3, fx(9.0), 0, 0);
    repeat (30) tick();
    chk("t5_frz", out[3], fx(6.0));
    repeat (3) tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) set_ch(0, fx(3.0), 0, 0);
      tick();
      chk("t5_en_upd", upd, 0);
    end
    en = 1'b1;
    tick();
    chk("t5_pend", cur_ch, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      rand_inputs(1'b1);
      tick();
    end

    // async reset while an upd strobe is high
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      rand_inputs(1'b0);
      pk_clr = 4'hF;
      tick();
      if (m_upd != 0) found = 1;
    end
    chk("t6_find", found, 1);
    pk_clr = '0;
    #2 rst = 1'b1;
    #1;
    chk("t6_out0", out[0], 0);
    chk("t6_out2", out[2], 0);
    chk("t6_upd", upd, 0);
    chk("t6_cnt", upd_cnt, 0);
    model_reset();
    #3 rst = 1'b0;
    repeat (4) tick();
    chk("t6_reload", upd_cnt, m_cnt);
    for (int i = 0; i < 100; i++) begin
      rand_inputs(1'b1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
